// File: rtl/somador_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package somador_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/somador_nibble.sv
// 4-bit ripple-carry adder built from full-adder bit cells.
module somador_nibble
    import somador_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/controle_somador.sv
// WIDTH-bit add/subtract computed one nibble per clock on a single shared
// nibble adder. Handshakes: a transfer happens on a rising edge where valid & ready.
module controle_somador
    import somador_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / NIB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
        $error("controle_somador: WIDTH must be a positive multiple of 4");
    end

    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    estado_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_eff;
    logic             carry_r;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_s;
    logic             nib_cout;
    logic [WIDTH-1:0] s_upd;

    assign nib_a = a_r[idx*NIB_W +: NIB_W];
    assign nib_b = b_eff[idx*NIB_W +: NIB_W];

    somador_nibble u_nibble (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_r),
        .s    (nib_s),
        .cout (nib_cout)
    );

    // Result word with the current nibble merged in; feeds both s_r and the flags.
    always_comb begin
        s_upd = s_r;
        s_upd[idx*NIB_W +: NIB_W] = nib_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_eff   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            s_r     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_r     <= a;
                        b_eff   <= op_sub ? ~b : b;
                        carry_r <= op_sub;
                        idx     <= '0;
                        s_r     <= '0;
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        zero_r  <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    s_r     <= s_upd;
                    carry_r <= nib_cout;
                    idx     <= idx + 1'b1;
                    // Flags are registered on the last nibble so they are stable in DONE.
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        cout_r <= nib_cout;
                        ovf_r  <= ovf_calc(a_r[WIDTH-1], b_eff[WIDTH-1], s_upd[WIDTH-1]);
                        zero_r <= (s_upd == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state == CALC);
    assign res_valid = (state == DONE);
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule
